// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
//   Shared definitions for the fetch stage:
//     - fetch FSM state encoding (S_REQ / S_WAIT / S_HOLD)
//     - PC increment step for sequential fetch
//     - default reset PC
// -----------------------------------------------------------------------------
package fetch_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,  // request channel may issue a fetch
        S_WAIT = 2'd1,  // exactly one request outstanding
        S_HOLD = 2'd2   // response captured, waiting for decode to unstall
    } fetch_state_e;

    localparam logic [63:0] FETCH_PC_STEP          = 64'd4;
    localparam logic [63:0] FETCH_DEFAULT_RESET_PC = 64'h0000_0000_8000_0000;

endpackage : fetch_pkg

// File: rtl/fetch_out_slot.sv
// -----------------------------------------------------------------------------
// fetch_out_slot
//   Output register of the fetch stage (feeds the decode pipeline register).
//   Update priority: flush (redirect) > stall > load > clear.
//   Also tracks the PC of the last delivered instruction so each delivery
//   can report the previous commit PC.
//
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   flush          : redirect; empties the slot
//   stall          : decode stalled; a full slot keeps its contents
//   load           : a fetched instruction is delivered this cycle
//   load_pc/instr  : instruction being delivered
//   commit         : slot holds a real instruction
//   pc / instr     : delivered instruction and its PC (0 when empty)
//   commit_pre_pc  : PC of the previously delivered instruction
// -----------------------------------------------------------------------------
module fetch_out_slot
    import fetch_pkg::*;
#(
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               stall,
    input  logic               load,
    input  logic [63:0]        load_pc,
    input  logic [INSTR_W-1:0] load_instr,
    output logic               commit,
    output logic [63:0]        pc,
    output logic [INSTR_W-1:0] instr,
    output logic [63:0]        commit_pre_pc
);

    logic               commit_q, commit_d;
    logic [63:0]        pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [63:0]        pre_pc_q, pre_pc_d;
    logic [63:0]        last_pc_q, last_pc_d;

    // Only a full slot needs protecting from stall: an empty slot already
    // holds zeros, so it may accept a load while decode is stalled and the
    // instruction simply waits here until decode takes it.
    logic hold_slot;
    assign hold_slot = stall && commit_q;

    always_comb begin
        // NOTE: every signal assigned here gets a default first; otherwise a
        // path that skips an assignment infers a latch.
        commit_d  = commit_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        pre_pc_d  = pre_pc_q;
        last_pc_d = last_pc_q;

        if (flush) begin
            commit_d = 1'b0;
            pc_d     = '0;
            instr_d  = '0;
        end else if (hold_slot) begin
            // keep every field
        end else if (load) begin
            commit_d  = 1'b1;
            pc_d      = load_pc;
            instr_d   = load_instr;
            pre_pc_d  = last_pc_q;
            last_pc_d = load_pc;
        end else begin
            commit_d = 1'b0;
            pc_d     = '0;
            instr_d  = '0;
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments so all
    // flops sample their _d values from the same edge, independent of order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            commit_q  <= 1'b0;
            pc_q      <= '0;
            instr_q   <= '0;
            pre_pc_q  <= '0;
            last_pc_q <= '0;
        end else begin
            commit_q  <= commit_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            pre_pc_q  <= pre_pc_d;
            last_pc_q <= last_pc_d;
        end
    end

    assign commit        = commit_q;
    assign pc            = pc_q;
    assign instr         = instr_q;
    assign commit_pre_pc = pre_pc_q;

endmodule : fetch_out_slot

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Producer side of the fetch->decode pipeline register. Generates the PC,
//   issues single-outstanding instruction-memory requests, buffers a response
//   that arrives while decode is stalled, and supplies difftest commit info.
//
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   stall                      : decode register stalled
//   redirect_valid/redirect_pc : fetch redirect (branch/jump/exception)
//   imem_req_valid/addr/ready  : instruction fetch request channel
//   imem_rsp_valid/data        : instruction fetch response channel
//   fetch_o_*                  : delivered instruction + commit info
//   perf_fetch_cnt             : (FETCH_PERF_CNT_EN) output-slot loads
//   perf_stall_cnt             : (FETCH_PERF_CNT_EN) cycles stalled with a
//                                 valid instruction in the slot
//
// Build option: define FETCH_PERF_CNT_EN to add the performance counters.
// -----------------------------------------------------------------------------
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC = FETCH_DEFAULT_RESET_PC,
    parameter int          INSTR_W  = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [63:0]        redirect_pc,
    output logic               imem_req_valid,
    output logic [63:0]        imem_req_addr,
    input  logic               imem_req_ready,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    output logic [63:0]        fetch_o_pc,
    output logic [INSTR_W-1:0] fetch_o_instr,
    output logic               fetch_o_commit,
    output logic [63:0]        fetch_o_commit_pc,
    output logic [INSTR_W-1:0] fetch_o_commit_instr,
`ifdef FETCH_PERF_CNT_EN
    output logic [63:0]        perf_fetch_cnt,
    output logic [63:0]        perf_stall_cnt,
`endif
    output logic [63:0]        fetch_o_commit_pre_pc
);

    fetch_state_e       state_q, state_d;
    logic [63:0]        pc_q, pc_d;
    logic               drop_q, drop_d;
    logic [63:0]        hold_pc_q, hold_pc_d;
    logic [INSTR_W-1:0] hold_instr_q, hold_instr_d;

    logic               slot_load;
    logic [63:0]        slot_load_pc;
    logic [INSTR_W-1:0] slot_load_instr;
    logic               slot_free;

    // The slot can take a new instruction unless it is full and decode stalls.
    assign slot_free = !stall || !fetch_o_commit;

    // The FSM register resets to S_REQ, so gate with rst_n to keep the
    // request channel quiet for the whole reset assertion.
    assign imem_req_valid = rst_n && (state_q == S_REQ) && !redirect_valid;
    assign imem_req_addr  = pc_q;

    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        drop_d          = drop_q;
        hold_pc_d       = hold_pc_q;
        hold_instr_d    = hold_instr_q;
        slot_load       = 1'b0;
        slot_load_pc    = '0;
        slot_load_instr = '0;

        unique case (state_q)
            S_REQ: begin
                // A late response landing here belongs to nothing; ignore it.
                if (redirect_valid) begin
                    pc_d = redirect_pc;
                end else if (imem_req_ready) begin
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                if (redirect_valid && imem_rsp_valid) begin
                    pc_d    = redirect_pc;
                    drop_d  = 1'b0;
                    state_d = S_REQ;
                end else if (redirect_valid) begin
                    // The outstanding response still has to be absorbed;
                    // remember to throw it away when it arrives.
                    pc_d   = redirect_pc;
                    drop_d = 1'b1;
                end else if (imem_rsp_valid) begin
                    if (drop_q) begin
                        // pc already holds the redirect target
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                    end else if (slot_free) begin
                        slot_load       = 1'b1;
                        slot_load_pc    = pc_q;
                        slot_load_instr = imem_rsp_data;
                        pc_d            = pc_q + FETCH_PC_STEP;
                        state_d         = S_REQ;
                    end else begin
                        hold_pc_d    = pc_q;
                        hold_instr_d = imem_rsp_data;
                        state_d      = S_HOLD;
                    end
                end
            end

            S_HOLD: begin
                if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    state_d = S_REQ;
                end else if (!stall) begin
                    slot_load       = 1'b1;
                    slot_load_pc    = hold_pc_q;
                    slot_load_instr = hold_instr_q;
                    pc_d            = pc_q + FETCH_PC_STEP;
                    state_d         = S_REQ;
                end
            end

            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_REQ;
            pc_q         <= RESET_PC;
            drop_q       <= 1'b0;
            hold_pc_q    <= '0;
            hold_instr_q <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drop_q       <= drop_d;
            hold_pc_q    <= hold_pc_d;
            hold_instr_q <= hold_instr_d;
        end
    end

    fetch_out_slot #(
        .INSTR_W (INSTR_W)
    ) u_out_slot (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (redirect_valid),
        .stall         (stall),
        .load          (slot_load),
        .load_pc       (slot_load_pc),
        .load_instr    (slot_load_instr),
        .commit        (fetch_o_commit),
        .pc            (fetch_o_pc),
        .instr         (fetch_o_instr),
        .commit_pre_pc (fetch_o_commit_pre_pc)
    );

    // Commit fields mirror the slot; an empty slot already reads as zero.
    assign fetch_o_commit_pc    = fetch_o_pc;
    assign fetch_o_commit_instr = fetch_o_instr;

`ifdef FETCH_PERF_CNT_EN
    logic [63:0] perf_fetch_q, perf_fetch_d;
    logic [63:0] perf_stall_q, perf_stall_d;

    // A load is only raised when the slot will accept it (redirect excluded),
    // so it counts real deliveries.
    always_comb begin
        perf_fetch_d = perf_fetch_q;
        perf_stall_d = perf_stall_q;
        if (slot_load && !redirect_valid) begin
            perf_fetch_d = perf_fetch_q + 64'd1;
        end
        if (stall && fetch_o_commit) begin
            perf_stall_d = perf_stall_q + 64'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_q <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_fetch_q <= perf_fetch_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_fetch_cnt = perf_fetch_q;
    assign perf_stall_cnt = perf_stall_q;
`endif

endmodule : fetch_stage

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//   Directed self-checking bench for fetch_stage. Inputs change 2 time units
//   after the rising edge; outputs are sampled at that point (registered
//   outputs) or 1 unit after an input change (combinational request outputs).
// -----------------------------------------------------------------------------
module tb_fetch_stage;

    localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        imem_req_valid;
    logic [63:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [63:0] fetch_o_pc;
    logic [31:0] fetch_o_instr;
    logic        fetch_o_commit;
    logic [63:0] fetch_o_commit_pc;
    logic [31:0] fetch_o_commit_instr;
    logic [63:0] fetch_o_commit_pre_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [63:0] perf_fetch_cnt;
    logic [63:0] perf_stall_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fetch_stage #(
        .RESET_PC (RST_PC),
        .INSTR_W  (32)
    ) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .stall                 (stall),
        .redirect_valid        (redirect_valid),
        .redirect_pc           (redirect_pc),
        .imem_req_valid        (imem_req_valid),
        .imem_req_addr         (imem_req_addr),
        .imem_req_ready        (imem_req_ready),
        .imem_rsp_valid        (imem_rsp_valid),
        .imem_rsp_data         (imem_rsp_data),
        .fetch_o_pc            (fetch_o_pc),
        .fetch_o_instr         (fetch_o_instr),
        .fetch_o_commit        (fetch_o_commit),
        .fetch_o_commit_pc     (fetch_o_commit_pc),
        .fetch_o_commit_instr  (fetch_o_commit_instr),
`ifdef FETCH_PERF_CNT_EN
        .perf_fetch_cnt        (perf_fetch_cnt),
        .perf_stall_cnt        (perf_stall_cnt),
`endif
        .fetch_o_commit_pre_pc (fetch_o_commit_pre_pc)
    );

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Checks request channel: expected valid, and address when valid.
    task automatic test_reset();
        rst_n          = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        #12;
        checks++;
        if (imem_req_valid !== 1'b0) begin
            failures++; $display("FAIL reset_req_valid: got %b want 0", imem_req_valid);
        end
        checks++;
        if ({fetch_o_commit, fetch_o_pc, fetch_o_instr, fetch_o_commit_pre_pc} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: commit=%b pc=%h instr=%h pre=%h want all 0",
                     fetch_o_commit, fetch_o_pc, fetch_o_instr, fetch_o_commit_pre_pc);
        end
        step();
        rst_n = 1'b1;
        #1;
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC) begin
            failures++;
            $display("FAIL reset_first_req: valid=%b addr=%h want 1/%h", imem_req_valid, imem_req_addr, RST_PC);
        end
    endtask

    task automatic test_sequential();
        imem_req_ready = 1'b1;
        step();                                  // request at 0x80000000 accepted
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0013;
        #1;
        checks++;
        if (imem_req_valid !== 1'b0) begin
            failures++; $display("FAIL seq_wait_no_req: got %b want 0", imem_req_valid);
        end
        step();
        imem_rsp_valid = 1'b0;
        #1;
        checks++;
        if (fetch_o_commit !== 1'b1 || fetch_o_pc !== RST_PC || fetch_o_instr !== 32'h0000_0013 ||
            fetch_o_commit_pre_pc !== 64'h0 || fetch_o_commit_pc !== RST_PC ||
            fetch_o_commit_instr !== 32'h0000_0013) begin
            failures++;
            $display("FAIL seq_first: commit=%b pc=%h instr=%h pre=%h want 1/%h/00000013/0",
                     fetch_o_commit, fetch_o_pc, fetch_o_instr, fetch_o_commit_pre_pc, RST_PC);
        end
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0004) begin
            failures++; $display("FAIL seq_req2: valid=%b addr=%h want 1/80000004", imem_req_valid, imem_req_addr);
        end
        step();
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0010_0093;
        checks++;
        if (fetch_o_commit !== 1'b0 || fetch_o_pc !== 64'h0) begin
            failures++; $display("FAIL seq_gap_empty: commit=%b pc=%h want 0/0", fetch_o_commit, fetch_o_pc);
        end
        step();
        imem_rsp_valid = 1'b0;
        checks++;
        if (fetch_o_commit !== 1'b1 || fetch_o_pc !== 64'h8000_0004 || fetch_o_instr !== 32'h0010_0093 ||
            fetch_o_commit_pre_pc !== RST_PC) begin
            failures++;
            $display("FAIL seq_second: commit=%b pc=%h instr=%h pre=%h want 1/80000004/00100093/%h",
                     fetch_o_commit, fetch_o_pc, fetch_o_instr, fetch_o_commit_pre_pc, RST_PC);
        end
    endtask

    task automatic test_stall_hold();
        stall = 1'b1;
        step();                                  // request 0x80000008 accepted, slot frozen
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'hAAAA_0001;
        checks++;
        if (fetch_o_commit !== 1'b1 || fetch_o_pc !== 64'h8000_0004 || fetch_o_instr !== 32'h0010_0093) begin
            failures++; $display("FAIL stall_frozen1: commit=%b pc=%h instr=%h want 1/80000004/00100093",
                                 fetch_o_commit, fetch_o_pc, fetch_o_instr);
        end
        step();                                  // response captured into hold buffer
        imem_rsp_valid = 1'b0;
        #1;
        checks++;
        if (fetch_o_pc !== 64'h8000_0004 || imem_req_valid !== 1'b0) begin
            failures++; $display("FAIL stall_hold1: pc=%h req_valid=%b want 80000004/0", fetch_o_pc, imem_req_valid);
        end
        step();
        checks++;
        if (fetch_o_commit !== 1'b1 || fetch_o_pc !== 64'h8000_0004 || imem_req_valid !== 1'b0) begin
            failures++; $display("FAIL stall_hold2: commit=%b pc=%h req_valid=%b want 1/80000004/0",
                                 fetch_o_commit, fetch_o_pc, imem_req_valid);
        end
        stall = 1'b0;
        step();
        #1;
        checks++;
        if (fetch_o_commit !== 1'b1 || fetch_o_pc !== 64'h8000_0008 || fetch_o_instr !== 32'hAAAA_0001 ||
            fetch_o_commit_pre_pc !== 64'h8000_0004) begin
            failures++; $display("FAIL stall_release: commit=%b pc=%h instr=%h pre=%h want 1/80000008/aaaa0001/80000004",
                                 fetch_o_commit, fetch_o_pc, fetch_o_instr, fetch_o_commit_pre_pc);
        end
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_000C) begin
            failures++; $display("FAIL stall_next_req: valid=%b addr=%h want 1/8000000c", imem_req_valid, imem_req_addr);
        end
        step();
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0517;
        checks++;
        if (fetch_o_commit !== 1'b0) begin
            failures++; $display("FAIL stall_no_dup: commit=%b want 0", fetch_o_commit);
        end
        step();
        imem_rsp_valid = 1'b0;
        checks++;
        if (fetch_o_pc !== 64'h8000_000C || fetch_o_instr !== 32'h0000_0517 || fetch_o_commit_pre_pc !== 64'h8000_0008) begin
            failures++; $display("FAIL stall_after: pc=%h instr=%h pre=%h want 8000000c/00000517/80000008",
                                 fetch_o_pc, fetch_o_instr, fetch_o_commit_pre_pc);
        end
    endtask

    task automatic test_redirect_wait();
        step();                                  // request 0x80000010 accepted
        redirect_valid = 1'b1; redirect_pc = 64'h8000_1000;
        step();                                  // redirect recorded, response pending
        redirect_valid = 1'b0;
        checks++;
        if (fetch_o_commit !== 1'b0 || fetch_o_pc !== 64'h0) begin
            failures++; $display("FAIL redir_flush: commit=%b pc=%h want 0/0", fetch_o_commit, fetch_o_pc);
        end
        step();
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
        step();                                  // stale response dropped
        imem_rsp_valid = 1'b0;
        #1;
        checks++;
        if (fetch_o_commit !== 1'b0 || fetch_o_instr !== 32'h0) begin
            failures++; $display("FAIL redir_drop: commit=%b instr=%h want 0/0", fetch_o_commit, fetch_o_instr);
        end
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_1000) begin
            failures++; $display("FAIL redir_req: valid=%b addr=%h want 1/80001000", imem_req_valid, imem_req_addr);
        end
    endtask

    task automatic test_redirect_rsp_stall();
        step();                                  // request 0x80001000 accepted
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0011;
        step();
        imem_rsp_valid = 1'b0;
        stall = 1'b1;
        checks++;
        if (fetch_o_commit !== 1'b1 || fetch_o_pc !== 64'h8000_1000 || fetch_o_commit_pre_pc !== 64'h8000_000C) begin
            failures++; $display("FAIL rrs_target: commit=%b pc=%h pre=%h want 1/80001000/8000000c",
                                 fetch_o_commit, fetch_o_pc, fetch_o_commit_pre_pc);
        end
        step();                                  // request 0x80001004 accepted, slot held
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0022;
        redirect_valid = 1'b1; redirect_pc = 64'h8000_2000;
        step();
        imem_rsp_valid = 1'b0; redirect_valid = 1'b0; stall = 1'b0;
        #1;
        checks++;
        if (fetch_o_commit !== 1'b0 || fetch_o_pc !== 64'h0 || fetch_o_instr !== 32'h0) begin
            failures++; $display("FAIL rrs_flush: commit=%b pc=%h instr=%h want 0/0/0", fetch_o_commit, fetch_o_pc, fetch_o_instr);
        end
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_2000) begin
            failures++; $display("FAIL rrs_req: valid=%b addr=%h want 1/80002000", imem_req_valid, imem_req_addr);
        end
    endtask

    task automatic test_wrap();
        redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        #1;
        checks++;
        if (imem_req_valid !== 1'b0) begin
            failures++; $display("FAIL wrap_req_masked: got %b want 0", imem_req_valid);
        end
        step();
        redirect_valid = 1'b0;
        #1;
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin
            failures++; $display("FAIL wrap_req_top: valid=%b addr=%h want 1/fffffffffffffffc", imem_req_valid, imem_req_addr);
        end
        step();
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0033;
        step();
        imem_rsp_valid = 1'b0;
        #1;
        checks++;
        if (fetch_o_commit !== 1'b1 || fetch_o_pc !== 64'hFFFF_FFFF_FFFF_FFFC || fetch_o_commit_pre_pc !== 64'h8000_1000) begin
            failures++; $display("FAIL wrap_deliver: commit=%b pc=%h pre=%h want 1/fffffffffffffffc/80001000",
                                 fetch_o_commit, fetch_o_pc, fetch_o_commit_pre_pc);
        end
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h0) begin
            failures++; $display("FAIL wrap_req_zero: valid=%b addr=%h want 1/0", imem_req_valid, imem_req_addr);
        end
    endtask

    task automatic test_async_reset();
        stall = 1'b1;                            // keep the slot full into S_WAIT
        step();                                  // request at 0 accepted
        rst_n = 1'b0;
        #1;
        checks++;
        if ({fetch_o_commit, fetch_o_pc, fetch_o_instr, fetch_o_commit_pre_pc} !== '0 || imem_req_valid !== 1'b0) begin
            failures++;
            $display("FAIL areset_immediate: commit=%b pc=%h instr=%h pre=%h req_valid=%b want all 0",
                     fetch_o_commit, fetch_o_pc, fetch_o_instr, fetch_o_commit_pre_pc, imem_req_valid);
        end
        stall = 1'b0;
        imem_req_ready = 1'b0;
        step();
        rst_n = 1'b1;
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0044;   // stray response
        #1;
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC) begin
            failures++; $display("FAIL areset_req: valid=%b addr=%h want 1/%h", imem_req_valid, imem_req_addr, RST_PC);
        end
        step();
        imem_rsp_valid = 1'b0;
        checks++;
        if (fetch_o_commit !== 1'b0 || fetch_o_instr !== 32'h0) begin
            failures++; $display("FAIL areset_stray: commit=%b instr=%h want 0/0", fetch_o_commit, fetch_o_instr);
        end
        imem_req_ready = 1'b1;
        step();
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0055;
        step();
        imem_rsp_valid = 1'b0;
        checks++;
        if (fetch_o_commit !== 1'b1 || fetch_o_pc !== RST_PC || fetch_o_instr !== 32'h0000_0055 ||
            fetch_o_commit_pre_pc !== 64'h0) begin
            failures++; $display("FAIL areset_first: commit=%b pc=%h instr=%h pre=%h want 1/%h/00000055/0",
                                 fetch_o_commit, fetch_o_pc, fetch_o_instr, fetch_o_commit_pre_pc, RST_PC);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall_hold();
        test_redirect_wait();
        test_redirect_rsp_stall();
        test_wrap();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_fetch_stage
